// File: rtl/register_file.sv
// 32x32 general-purpose register file for the single-cycle MIPS datapath.
// Two asynchronous read ports, one clocked write port, and register 0 always reads as zero.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  RegWr,
  input  logic [ADDR_WIDTH-1:0] Rw,
  input  logic [ADDR_WIDTH-1:0] Ra,
  input  logic [ADDR_WIDTH-1:0] Rb,
  input  logic [DATA_WIDTH-1:0] busW,
  output logic [DATA_WIDTH-1:0] busA,
  output logic [DATA_WIDTH-1:0] busB
);

  localparam int NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NumRegs];

  // Reset wins over a same-cycle write; writes aimed at register 0 are dropped.
  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWr && (Rw != '0)) begin
      regs[Rw] <= busW;
    end
  end

  // No write bypass: a read of the register being written shows the old value until the edge.
  assign busA = (Ra == '0) ? '0 : regs[Ra];
  assign busB = (Rb == '0) ? '0 : regs[Rb];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Expected values are hand-computed constants or a simple address-derived pattern.
module tb_register_file;

  logic        clk;
  logic        rstb;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [4:0]  Ra;
  logic [4:0]  Rb;
  logic [31:0] busW;
  logic [31:0] busA;
  logic [31:0] busB;

  int compared   = 0;
  int mismatched = 0;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .RegWr(RegWr),
    .Rw   (Rw),
    .Ra   (Ra),
    .Rb   (Rb),
    .busW (busW),
    .busA (busA),
    .busB (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison goes through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one clocked cycle, then return controls to idle just after the edge.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [4:0] addr, input logic [31:0] data);
    rstb  = rst;
    RegWr = wr;
    Rw    = addr;
    busW  = data;
    @(posedge clk);
    #1;
    rstb  = 1'b0;
    RegWr = 1'b0;
  endtask

  task automatic readBoth(input string tag, input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] expA, input logic [31:0] expB);
    Ra = a;
    Rb = b;
    #1;
    checkOutput({tag, "_A"}, busA, expA);
    checkOutput({tag, "_B"}, busB, expB);
  endtask

  function automatic logic [31:0] patternFor(input int idx);
    return (idx == 0) ? 32'h0 : (32'hA5000000 | (idx << 8) | (32'hFF - idx));
  endfunction

  initial begin
    rstb  = 1'b0;
    RegWr = 1'b0;
    Rw    = '0;
    Ra    = '0;
    Rb    = '0;
    busW  = '0;
    #2;

    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);

    // Fill every register with a distinct pattern, then read back crosswise.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, i[4:0], patternFor(i));
    end
    for (int i = 0; i < 32; i++) begin
      readBoth($sformatf("fill_r%0d", i), i[4:0], 5'(31 - i), patternFor(i), patternFor(31 - i));
    end

    // Reset after writes clears everything.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      readBoth($sformatf("reset_r%0d", i), i[4:0], i[4:0], 32'h0, 32'h0);
    end

    applyStimulus(1'b0, 1'b1, 5'd23, 32'h0000FF23);
    applyStimulus(1'b0, 1'b1, 5'd17, 32'h0000FF17);
    applyStimulus(1'b0, 1'b1, 5'd31, 32'h0000FF31);
    readBoth("wr_23_17", 5'd23, 5'd17, 32'h0000FF23, 32'h0000FF17);
    readBoth("wr_31_31", 5'd31, 5'd31, 32'h0000FF31, 32'h0000FF31);

    applyStimulus(1'b0, 1'b1, 5'd0, 32'h0000FF00);
    readBoth("r0_protect", 5'd0, 5'd0, 32'h0, 32'h0);

    applyStimulus(1'b0, 1'b0, 5'd23, 32'hDEADBEEF);
    readBoth("wr_gated", 5'd23, 5'd17, 32'h0000FF23, 32'h0000FF17);

    applyStimulus(1'b0, 1'b1, 5'd5, 32'h11111111);
    Ra    = 5'd5;
    Rb    = 5'd5;
    RegWr = 1'b1;
    Rw    = 5'd5;
    busW  = 32'h22222222;
    #1;
    checkOutput("rdw_before_A", busA, 32'h11111111);
    checkOutput("rdw_before_B", busB, 32'h11111111);
    @(posedge clk);
    #1;
    RegWr = 1'b0;
    checkOutput("rdw_after_A", busA, 32'h22222222);
    checkOutput("rdw_after_B", busB, 32'h22222222);

    applyStimulus(1'b0, 1'b1, 5'd9, 32'h99999999);
    readBoth("pre_prio", 5'd9, 5'd23, 32'h99999999, 32'h0000FF23);
    applyStimulus(1'b1, 1'b1, 5'd9, 32'hABCD1234);
    readBoth("reset_prio", 5'd9, 5'd23, 32'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
